// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcodes, FSM states and status-byte layout shared by spi_cmd_parser
package spi_cmd_pkg;
  localparam int ADDR_W = 16;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam int ST_BAD_OP = 7;
  localparam int ST_SHORT  = 6;
  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_ADDR_HI, S_ADDR_LO, S_WRITE, S_READ, S_STATUS, S_DISCARD
  } state_t;
  function automatic logic [7:0] status_byte(input logic bad, input logic short_fr);
    status_byte = 8'h00;
    status_byte[ST_BAD_OP] = bad;
    status_byte[ST_SHORT] = short_fr;
  endfunction
endpackage

// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: framed SPI command decoder driving byte-wide register write/read ports
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   rx_valid, rx_data     received byte strobe and data from the SPI slave
//   msg_start, msg_end    chip-select assert / release strobes
//   wr_en/wr_addr/wr_data register write port
//   rd_en/rd_addr/rd_data register read port (rd_data valid one cycle after rd_en)
//   tx_valid, tx_data     next MISO byte (read data or status)
//   err                   sticky OR of the status error flags
// Build option: SPI_CMD_ERRCNT_EN adds a saturating error counter returned as the second STATUS byte.
module spi_cmd_parser #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              msg_start,
  input  logic              msg_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              err
);
  import spi_cmd_pkg::*;
  state_t state, next_state, ns_byte;
  logic [ADDR_W-1:0] addr;
  logic [7:0] st_data, cnt_byte;
  logic op_rd, st_done, bad_op, short_frame, rd_pend, st_tx;
  logic op_valid, op_byte, hi_byte, lo_byte, wr_byte, rd_byte, st_byte, st_op, set_bad, set_short;
  assign op_valid = rx_data == OP_WRITE || rx_data == OP_READ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next_state;
  // ns_byte is where the current byte alone would take us; chip-select events then override it,
  // so a byte arriving with msg_end is still processed before returning to IDLE.
  always_comb begin
    ns_byte = !rx_valid ? state :
              state == S_OPCODE  ? (rx_data == OP_STATUS ? S_STATUS : op_valid ? S_ADDR_HI : S_DISCARD) :
              state == S_ADDR_HI ? S_ADDR_LO :
              state == S_ADDR_LO ? (op_rd ? S_READ : S_WRITE) : state;
    next_state = msg_end ? S_IDLE : msg_start ? S_OPCODE : ns_byte;
  end
  always_comb begin
    op_byte = rx_valid && state == S_OPCODE;
    hi_byte = rx_valid && state == S_ADDR_HI;
    lo_byte = rx_valid && state == S_ADDR_LO;
    wr_byte = rx_valid && state == S_WRITE;
    rd_byte = rx_valid && state == S_READ;
    st_byte = rx_valid && state == S_STATUS && !st_done;
    st_op = op_byte && rx_data == OP_STATUS;
    set_bad = op_byte && !op_valid && rx_data != OP_STATUS;
    set_short = msg_end ? ns_byte inside {S_OPCODE, S_ADDR_HI, S_ADDR_LO} :
                msg_start && ns_byte inside {S_ADDR_HI, S_ADDR_LO};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      op_rd <= 1'b0;
      st_done <= 1'b0;
      bad_op <= 1'b0;
      short_frame <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
      rd_en <= 1'b0;
      rd_addr <= '0;
      rd_pend <= 1'b0;
      st_tx <= 1'b0;
      st_data <= 8'h00;
    end else begin
      wr_en <= wr_byte;
      rd_en <= (lo_byte && op_rd) || rd_byte;
      rd_pend <= rd_en;
      st_tx <= st_op || st_byte;
      if (op_byte) op_rd <= rx_data == OP_READ;
      if (hi_byte) addr[ADDR_W-1:8] <= rx_data;
      if (lo_byte) addr[7:0] <= rx_data;
      if (wr_byte || rd_byte) addr <= addr + ADDR_W'(1);
      if (wr_byte) begin
        wr_addr <= addr;
        wr_data <= rx_data;
      end
      if (lo_byte && op_rd) rd_addr <= {addr[ADDR_W-1:8], rx_data};
      if (rd_byte) rd_addr <= addr + ADDR_W'(1);
      if (st_op) st_data <= status_byte(bad_op, short_frame);
      if (st_byte) st_data <= cnt_byte;
      st_done <= op_byte ? 1'b0 : st_done | st_byte;
      bad_op <= set_bad | (bad_op & ~st_byte);
      short_frame <= set_short | (short_frame & ~st_byte);
    end
`ifdef SPI_CMD_ERRCNT_EN
  logic [7:0] err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= 8'h00;
    else err_cnt <= st_byte ? 8'h00 : (set_bad || set_short) && err_cnt != 8'hFF ? err_cnt + 8'd1 : err_cnt;
  assign cnt_byte = err_cnt;
`else
  assign cnt_byte = 8'h00;
`endif
  // Read data comes straight from the memory in the cycle after rd_en, so it bypasses st_data.
  assign tx_valid = rd_pend | st_tx;
  assign tx_data = rd_pend ? rd_data : st_data;
  assign err = bad_op | short_frame;
endmodule

// File: doc/spi_cmd_parser.md
# spi_cmd_parser

Byte-level command decoder sitting directly downstream of the SPI slave interface. Consumes the received-byte strobe and data plus the chip-select start/end events, parses framed commands (opcode, 16-bit address, payload), and drives a byte-wide register/memory write port and read port. Returns read data and status bytes to the SPI slave's transmit path so the host sees them on MISO during the following byte slot.

## Interface
Parameters:
- ADDR_W, 16, address width; fixed at 16 by the frame format (two address bytes).

Ports:
- clk  in  1  system clock, same domain as the SPI slave
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe: a complete byte has been received
- rx_data  in  8  received byte, valid with rx_valid
- msg_start  in  1  one-cycle strobe: chip-select asserted
- msg_end  in  1  one-cycle strobe: chip-select released
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  16  write address
- wr_data  out  8  write data
- rd_en  out  1  one-cycle read request
- rd_addr  out  16  read address
- rd_data  in  8  read data, valid exactly one cycle after rd_en
- tx_valid  out  1  one-cycle strobe: load tx_data as next MISO byte
- tx_data  out  8  response byte
- err  out  1  sticky error flag (any status error bit set)

## Operation
- Frame: byte0 opcode, byte1 addr[15:8], byte2 addr[7:0], then payload. Opcodes: 0x01 WRITE, 0x02 READ, 0x03 STATUS.
- States: IDLE, OPCODE, ADDR_HI, ADDR_LO, WRITE, READ, STATUS, DISCARD.
- IDLE --msg_start--> OPCODE. rx_valid in IDLE is ignored.
- OPCODE: 0x01/0x02 -> ADDR_HI; 0x03 -> STATUS (no address bytes); other -> DISCARD, set bad_op.
- ADDR_HI -> ADDR_LO -> WRITE or READ, loading the address register.
- WRITE: each rx_valid -> wr_en with current address and byte; address then increments.
- READ: on entry issue rd_en at the loaded address; on each later rx_valid (dummy byte) increment address, issue rd_en.
- Every rd_data return produces tx_valid/tx_data.
- STATUS: on entry emit tx_valid with status byte {bad_op, short_frame, 6'b0}; the following rx_valid clears both flags.
- DISCARD: ignore bytes until msg_end.
- msg_end in any state -> IDLE. In OPCODE, ADDR_HI or ADDR_LO (header incomplete) set short_frame.
- msg_start outside IDLE: abort current frame, go to OPCODE. Set short_frame if aborting from ADDR_HI or ADDR_LO.
- Address arithmetic is modulo 2^16: 0xFFFF increments to 0x0000.

## Timing
- Reset values: all strobes 0; wr_addr, wr_data, rd_addr, tx_data 0x00; err 0; state IDLE; flags clear.
- wr_en asserts exactly 1 cycle after the rx_valid carrying the data.
- rd_en asserts 1 cycle after the triggering rx_valid (or after entering READ). tx_valid follows 1 cycle after rd_en, so total latency is 2 cycles from the byte.
- Status tx_valid: 1 cycle after the opcode rx_valid.
- Simultaneous rx_valid and msg_end: process the byte first, then IDLE in the same update. Simultaneous msg_start and msg_end: msg_end wins, giving IDLE.
- Upstream guarantees at least 8 cycles between rx_valid strobes; no input buffering.
- Reset mid-frame: immediate return to reset values. Any in-flight read response is dropped.

## Configuration
- SPI_CMD_ERRCNT_EN: defined -> 8-bit saturating error counter, incremented on each bad_op or short_frame event. STATUS sends a second byte (the counter) after the flag byte, on the next rx_valid. Reading it clears the counter.
- Not defined: no counter logic. The second STATUS slot returns 0x00.

## Structure
- Package spi_cmd_pkg: opcode localparams (OP_WRITE, OP_READ, OP_STATUS), state enum, ADDR_W constant, status-bit index constants.
- Single module. No sub-module; the FSM and address counter are too tightly coupled to split.

## Test plan
- Write frame: 01 12 34 AA BB -> wr_en twice: (0x1234,0xAA), (0x1235,0xBB); each 1 cycle after its rx_valid.
- Read frame: 02 FF FF xx, memory model returns addr[7:0] -> rd_addr 0xFFFF then 0x0000; tx_data 0xFF then 0x00.
- Bad opcode: 7E 00 00, then STATUS frame 03 xx -> no wr/rd strobes; status tx_data 0x80, err=1; after dummy byte, next STATUS returns 0x00 and err=0.
- Short frame: 01 12 then msg_end -> no wr_en, short_frame set (status 0x40). Also msg_start during ADDR_LO -> abort, flag set, new frame decodes normally.
- Assert rst_n low mid-WRITE payload -> all outputs 0 immediately; next payload bytes before msg_start are ignored.
- ERRCNT_EN build: 3 bad opcodes, then STATUS -> second byte 0x03; repeat STATUS -> 0x00. Non-EN build -> second byte 0x00.
